// File: rtl/scan_flush_arbiter.sv
// Downlink arbiter for the primary/alternate scanners: grants one side, drives its
// flush until FLUSHING, holds the grant until LOW_PWR, then cools down before re-arbitrating.
module scan_flush_arbiter #(
   parameter int ACK_TIMEOUT = 16,
   parameter int COOL_CYCLES = 4,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             clr_err,
   input  logic [2:0]       state_a,
   input  logic [7:0]       mem_used_a,
   input  logic [2:0]       state_b,
   input  logic [7:0]       mem_used_b,
   output logic             flush_a,
   output logic             flush_b,
   output logic             grant_a,
   output logic             grant_b,
   output logic             link_busy,
   output logic             err_a,
   output logic             err_b,
   output logic [CNT_W-1:0] flush_cnt_a,
   output logic [CNT_W-1:0] flush_cnt_b
);

   localparam logic [2:0] ST_LOW_PWR  = 3'b000;
   localparam logic [2:0] ST_SCANNING = 3'b010;
   localparam logic [2:0] ST_IDLE     = 3'b011;
   localparam logic [2:0] ST_FLUSHING = 3'b100;

   localparam int TMAX = (ACK_TIMEOUT > COOL_CYCLES) ? ACK_TIMEOUT : COOL_CYCLES;
   localparam int TW   = $clog2(TMAX) + 1;

   typedef enum logic [2:0] {IDLE, REQ_A, XFER_A, REQ_B, XFER_B, COOL} fsm_t;

   fsm_t            fsm, fsm_nxt;
   logic [TW-1:0]   timer, timer_nxt;
   logic            last_b, last_b_nxt;
   logic            req_a, req_b;
   logic            set_err_a, set_err_b, inc_a, inc_b;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign req_a = ((state_a == ST_SCANNING) && (mem_used_a >= 8'd80)) || (state_a == ST_IDLE);
   assign req_b = ((state_b == ST_SCANNING) && (mem_used_b >= 8'd80)) || (state_b == ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm         <= IDLE;
         timer       <= '0;
         last_b      <= 1'b1;
         err_a       <= 1'b0;
         err_b       <= 1'b0;
         flush_cnt_a <= '0;
         flush_cnt_b <= '0;
      end else begin
         fsm    <= fsm_nxt;
         timer  <= timer_nxt;
         last_b <= last_b_nxt;
         // a timeout in the same cycle as clr_err leaves the error set
         err_a  <= set_err_a | (err_a & ~clr_err);
         err_b  <= set_err_b | (err_b & ~clr_err);
         if (inc_a) flush_cnt_a <= sat_inc(flush_cnt_a);
         if (inc_b) flush_cnt_b <= sat_inc(flush_cnt_b);
      end
   end

   always_comb begin
      fsm_nxt    = fsm;
      timer_nxt  = timer;
      last_b_nxt = last_b;
      set_err_a  = 1'b0;
      set_err_b  = 1'b0;
      inc_a      = 1'b0;
      inc_b      = 1'b0;
      case (fsm)
         IDLE: begin
            if (en && (req_a || req_b)) begin
               timer_nxt = '0;
               // on equal occupancy the side that did not win last time goes first
               if (req_a && (!req_b || (mem_used_a > mem_used_b) ||
                             ((mem_used_a == mem_used_b) && last_b))) begin
                  fsm_nxt    = REQ_A;
                  last_b_nxt = 1'b0;
               end else begin
                  fsm_nxt    = REQ_B;
                  last_b_nxt = 1'b1;
               end
            end
         end
         REQ_A: begin
            if (state_a == ST_FLUSHING) begin
               fsm_nxt = XFER_A;
            end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
               fsm_nxt   = COOL;
               timer_nxt = '0;
               set_err_a = 1'b1;
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end
         REQ_B: begin
            if (state_b == ST_FLUSHING) begin
               fsm_nxt = XFER_B;
            end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
               fsm_nxt   = COOL;
               timer_nxt = '0;
               set_err_b = 1'b1;
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end
         XFER_A: begin
            if (state_a == ST_LOW_PWR) begin
               fsm_nxt   = COOL;
               timer_nxt = '0;
               inc_a     = 1'b1;
            end
         end
         XFER_B: begin
            if (state_b == ST_LOW_PWR) begin
               fsm_nxt   = COOL;
               timer_nxt = '0;
               inc_b     = 1'b1;
            end
         end
         COOL: begin
            if (timer == TW'(COOL_CYCLES - 1)) begin
               fsm_nxt   = IDLE;
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + TW'(1);
            end
         end
         default: begin
            fsm_nxt   = IDLE;
            timer_nxt = '0;
         end
      endcase
   end

   assign flush_a   = (fsm == REQ_A);
   assign flush_b   = (fsm == REQ_B);
   assign grant_a   = (fsm == REQ_A) || (fsm == XFER_A);
   assign grant_b   = (fsm == REQ_B) || (fsm == XFER_B);
   assign link_busy = grant_a || grant_b || (fsm == COOL);

endmodule

// File: tb/tb_scan_flush_arbiter.sv
// Directed bench for scan_flush_arbiter: vector table for the basic grant/cooldown flow,
// hand sequences for ties, timeout, enable gating, counter saturation and reset.
module tb_scan_flush_arbiter;

   localparam logic [2:0] LP = 3'b000, STBY = 3'b001, SCAN = 3'b010, IDL = 3'b011, FL = 3'b100;

   logic       clk = 1'b0;
   logic       reset, en, clr_err;
   logic [2:0] state_a, state_b;
   logic [7:0] mem_used_a, mem_used_b;
   logic       flush_a, flush_b, grant_a, grant_b, link_busy, err_a, err_b;
   logic [7:0] flush_cnt_a, flush_cnt_b;
   logic [6:0] flags;

   int n_vec = 0;
   int n_err = 0;

   scan_flush_arbiter #(.ACK_TIMEOUT(16), .COOL_CYCLES(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .en(en), .clr_err(clr_err),
      .state_a(state_a), .mem_used_a(mem_used_a), .state_b(state_b), .mem_used_b(mem_used_b),
      .flush_a(flush_a), .flush_b(flush_b), .grant_a(grant_a), .grant_b(grant_b),
      .link_busy(link_busy), .err_a(err_a), .err_b(err_b),
      .flush_cnt_a(flush_cnt_a), .flush_cnt_b(flush_cnt_b)
   );

   always #5 clk = ~clk;

   assign flags = {flush_a, flush_b, grant_a, grant_b, link_busy, err_a, err_b};

   typedef struct {
      logic [2:0] sa;
      logic [7:0] ma;
      logic [2:0] sb;
      logic [7:0] mb;
      logic       en;
      logic [6:0] flags;
      logic [7:0] ca;
      logic [7:0] cb;
   } vec_t;

   vec_t vt[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] sa, input logic [7:0] ma,
                        input logic [2:0] sb, input logic [7:0] mb);
      state_a = sa; mem_used_a = ma; state_b = sb; mem_used_b = mb;
   endtask

   task automatic do_reset();
      reset = 1'b1; en = 1'b1; clr_err = 1'b0;
      drive(LP, 8'd0, LP, 8'd0);
      step(); step();
      reset = 1'b0;
   endtask

   initial begin
      int n;
      // flags = {flush_a, flush_b, grant_a, grant_b, link_busy, err_a, err_b}
      vt[0]  = '{IDL,  8'd100, LP,   8'd0,  1'b1, 7'b1010100, 8'd0, 8'd0};
      vt[1]  = '{FL,   8'd100, LP,   8'd0,  1'b1, 7'b0010100, 8'd0, 8'd0};
      vt[2]  = '{FL,   8'd50,  LP,   8'd0,  1'b1, 7'b0010100, 8'd0, 8'd0};
      vt[3]  = '{LP,   8'd0,   LP,   8'd0,  1'b1, 7'b0000100, 8'd1, 8'd0};
      vt[4]  = '{LP,   8'd0,   LP,   8'd0,  1'b1, 7'b0000100, 8'd1, 8'd0};
      vt[5]  = '{LP,   8'd0,   LP,   8'd0,  1'b1, 7'b0000100, 8'd1, 8'd0};
      vt[6]  = '{LP,   8'd0,   LP,   8'd0,  1'b1, 7'b0000100, 8'd1, 8'd0};
      vt[7]  = '{LP,   8'd0,   LP,   8'd0,  1'b1, 7'b0000000, 8'd1, 8'd0};
      vt[8]  = '{SCAN, 8'd85,  SCAN, 8'd92, 1'b1, 7'b0101100, 8'd1, 8'd0};
      vt[9]  = '{SCAN, 8'd85,  FL,   8'd92, 1'b1, 7'b0001100, 8'd1, 8'd0};
      vt[10] = '{LP,   8'd0,   LP,   8'd0,  1'b1, 7'b0000100, 8'd1, 8'd1};
      vt[11] = '{LP,   8'd0,   LP,   8'd0,  1'b1, 7'b0000100, 8'd1, 8'd1};
      vt[12] = '{LP,   8'd0,   LP,   8'd0,  1'b1, 7'b0000100, 8'd1, 8'd1};
      vt[13] = '{LP,   8'd0,   LP,   8'd0,  1'b1, 7'b0000100, 8'd1, 8'd1};
      vt[14] = '{LP,   8'd0,   LP,   8'd0,  1'b1, 7'b0000000, 8'd1, 8'd1};
      vt[15] = '{SCAN, 8'd79,  STBY, 8'd99, 1'b1, 7'b0000000, 8'd1, 8'd1};
      vt[16] = '{SCAN, 8'd80,  LP,   8'd0,  1'b1, 7'b1010100, 8'd1, 8'd1};
      vt[17] = '{SCAN, 8'd20,  IDL,  8'd0,  1'b1, 7'b1010100, 8'd1, 8'd1};

      // reset state
      do_reset();
      check("reset_flags", 32'(flags), 32'h0);
      check("reset_cnts", {16'h0, flush_cnt_a, flush_cnt_b}, 32'h0);

      // table: grant/ack/drain/cooldown, occupancy priority, threshold at 80
      for (int i = 0; i < 18; i++) begin
         drive(vt[i].sa, vt[i].ma, vt[i].sb, vt[i].mb);
         en = vt[i].en;
         step();
         check($sformatf("vec%0d", i), {9'h0, flags, flush_cnt_a, flush_cnt_b},
               {9'h0, vt[i].flags, vt[i].ca, vt[i].cb});
      end

      // tie after reset goes to A, next tie to B; no grant while cooling
      do_reset();
      drive(SCAN, 8'd90, SCAN, 8'd90);
      step();
      check("tie1_grant", {grant_a, grant_b}, 2'b10);
      drive(FL, 8'd90, SCAN, 8'd90);  step();
      drive(LP, 8'd0,  SCAN, 8'd90);  step();
      drive(SCAN, 8'd90, SCAN, 8'd90);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         if (grant_a || grant_b) n++;
         step();
      end
      check("cool_no_grant", n, 0);
      check("idle_after_cool", {grant_a, grant_b, link_busy}, 3'b000);
      step();
      check("tie2_grant", {grant_a, grant_b}, 2'b01);

      // ack timeout: flush_a held for exactly 16 cycles, then error and cooldown
      do_reset();
      drive(SCAN, 8'd85, LP, 8'd0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (flush_a) n++;
         else if (n > 0) break;
      end
      check("timeout_len", n, 16);
      check("timeout_state", {err_a, err_b, grant_a, link_busy}, 4'b1001);
      drive(LP, 8'd0, LP, 8'd0);
      clr_err = 1'b1; step(); clr_err = 1'b0;
      check("clr_err", err_a, 1'b0);

      // enable gating in IDLE, no effect on a grant already in progress
      do_reset();
      en = 1'b0;
      drive(IDL, 8'd100, LP, 8'd0);
      step(); step(); step();
      check("en0_no_grant", {grant_a, link_busy}, 2'b00);
      en = 1'b1; step();
      check("en1_grant", {flush_a, grant_a}, 2'b11);
      drive(FL, 8'd100, LP, 8'd0); step();
      en = 1'b0; step(); step();
      check("en0_xfer_hold", {flush_a, grant_a}, 2'b01);
      drive(LP, 8'd0, LP, 8'd0); step();
      check("en0_xfer_done", {grant_a, link_busy, flush_cnt_a}, {2'b01, 8'd1});

      // counter saturation on B, then reset in the middle of a transfer
      do_reset();
      for (int k = 0; k < 256; k++) begin
         drive(LP, 8'd0, IDL, 8'd0); step();
         drive(LP, 8'd0, FL,  8'd0); step();
         drive(LP, 8'd0, LP,  8'd0); step();
         step(); step(); step(); step();
         if (k == 254) check("cnt_b_255", flush_cnt_b, 8'd255);
      end
      check("cnt_b_sat", flush_cnt_b, 8'd255);
      drive(LP, 8'd0, IDL, 8'd0); step();
      drive(LP, 8'd0, FL,  8'd0); step();
      check("pre_reset_xfer", {grant_b, link_busy}, 2'b11);
      reset = 1'b1; step(); reset = 1'b0;
      check("reset_mid_xfer", {9'h0, flags, flush_cnt_a, flush_cnt_b}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
